axis_gate_counter: RTL and testbench

//  Gated edge counter fed by the constant AXI4-Stream source (gate length in aclk cycles).

---
 rtl/axis_gate_counter_pkg.sv | 14 +
 rtl/axis_gate_counter_edge_sync.sv | 32 +++
 rtl/axis_gate_counter.sv | 127 ++++++++++++
 tb/tb_axis_gate_counter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gate_counter_pkg.sv
// Shared types and constants for the gated AXI4-Stream edge counter.
package axis_gate_counter_pkg;

  localparam int unsigned StateWidth    = 2;
  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StGate,
    StHold
  } state_e;

endpackage

// File: rtl/axis_gate_counter_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge pulse.
module axis_gate_counter_edge_sync
  import axis_gate_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic sig_in,
  output logic edge_pulse
);

  // Out-of-range depths are clamped to the legal range.
  localparam int unsigned Stages = (SYNC_STAGES < SyncStagesMin) ? SyncStagesMin :
                                   (SYNC_STAGES > SyncStagesMax) ? SyncStagesMax : SYNC_STAGES;

  logic [Stages-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], sig_in};
      hist_q <= sync_q[Stages-1];
    end
  end

  assign edge_pulse = sync_q[Stages-1] & ~hist_q;

endmodule

// File: rtl/axis_gate_counter.sv
// Gated edge counter: takes a gate length on s_axis, counts sig_in rising edges for that many
// cycles, returns the count on m_axis. Define AXIS_GATE_CNT_SAT_EN for saturation + m_axis_tuser.
module axis_gate_counter
  import axis_gate_counter_pkg::*;
#(
  parameter int unsigned GATE_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  sig_in,
  input  logic [GATE_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [CNT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef AXIS_GATE_CNT_SAT_EN
  ,
  output logic                  m_axis_tuser
`endif
);

  state_e                state_q, state_d;
  logic                  armed_q;
  logic [GATE_WIDTH-1:0] gate_rem_q, gate_rem_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]  result_q, result_d;
  logic                  edge_pulse;

  axis_gate_counter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .sig_in    (sig_in),
    .edge_pulse(edge_pulse)
  );

`ifdef AXIS_GATE_CNT_SAT_EN
  logic ovf_q, ovf_d, ovf_set;

  always_comb begin
    cnt_inc = cnt_q + CNT_WIDTH'(edge_pulse);
    ovf_set = 1'b0;
    if (edge_pulse && (cnt_q == '1)) begin
      cnt_inc = cnt_q;
      ovf_set = 1'b1;
    end
  end

  assign m_axis_tuser = ovf_q;
`else
  always_comb begin
    cnt_inc = cnt_q + CNT_WIDTH'(edge_pulse);
  end
`endif

  always_comb begin
    state_d    = state_q;
    gate_rem_d = gate_rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
`ifdef AXIS_GATE_CNT_SAT_EN
    ovf_d      = ovf_q;
`endif
    // armed_q keeps tready low until the first clock after reset release.
    s_axis_tready = armed_q && (state_q == StIdle);
    m_axis_tvalid = (state_q == StHold);

    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid && armed_q) begin
          gate_rem_d = (s_axis_tdata == '0) ? GATE_WIDTH'(1) : s_axis_tdata;
          cnt_d      = '0;
`ifdef AXIS_GATE_CNT_SAT_EN
          ovf_d      = 1'b0;
`endif
          state_d    = StGate;
        end
      end
      StGate: begin
        cnt_d      = cnt_inc;
        gate_rem_d = gate_rem_q - GATE_WIDTH'(1);
`ifdef AXIS_GATE_CNT_SAT_EN
        ovf_d      = ovf_q | ovf_set;
`endif
        if (gate_rem_q == GATE_WIDTH'(1)) begin
          result_d = cnt_inc;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (m_axis_tready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      armed_q    <= 1'b0;
      gate_rem_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
`ifdef AXIS_GATE_CNT_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      gate_rem_q <= gate_rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
`ifdef AXIS_GATE_CNT_SAT_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign m_axis_tdata = result_q;

endmodule

// File: tb/tb_axis_gate_counter.sv
// Directed self-checking bench for axis_gate_counter; a 4-bit-counter instance covers wrap and
// saturation (AXIS_GATE_CNT_SAT_EN selects which result is expected).
module tb_axis_gate_counter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        sig_in;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready, s4_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m4_tdata;
  logic        m_axis_tvalid, m4_tvalid;
  logic        m_axis_tready;
`ifdef AXIS_GATE_CNT_SAT_EN
  logic        m_axis_tuser, m4_tuser;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   sig_period = 0;
  int   sig_ph   = 0;
  logic sv [0:4095];

  always #5 aclk = ~aclk;

  axis_gate_counter #(.GATE_WIDTH(32), .CNT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .sig_in       (sig_in),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_GATE_CNT_SAT_EN
    ,
    .m_axis_tuser (m_axis_tuser)
`endif
  );

  axis_gate_counter #(.GATE_WIDTH(32), .CNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .sig_in       (sig_in),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s4_tready),
    .m_axis_tdata (m4_tdata),
    .m_axis_tvalid(m4_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_GATE_CNT_SAT_EN
    ,
    .m_axis_tuser (m4_tuser)
`endif
  );

  // One clock; outputs sampled 1 time unit after the edge; sig_in advanced and recorded
  // as the value the next edge will capture.
  task automatic step();
    @(posedge aclk);
    cyc++;
    #1;
    if (sig_period != 0) begin
      sig_ph = (sig_ph + 1) % sig_period;
      sig_in = (sig_ph < sig_period / 2);
    end
    if (cyc + 1 < 4096) sv[cyc+1] = sig_in;
  endtask

  task automatic start_gate(input int n, output int acc);
    int guard = 0;
    while (!s_axis_tready && guard < 100) begin
      step();
      guard++;
    end
    s_axis_tdata  = n;
    s_axis_tvalid = 1'b1;
    step();
    acc = cyc;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int w = 0;
    do begin
      step();
      w++;
    end while (!m_axis_tvalid && w < max);
  endtask

  // Pulse counted at edge t comes from a 0->1 of sig_in captured at edges t-3 -> t-2.
  function automatic int pulses(input int a, input int b);
    int s = 0;
    for (int t = a; t <= b; t++) if (sv[t-2] && !sv[t-3]) s++;
    return s;
  endfunction

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_s_tready: got %b expected 0", s_axis_tready);
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_axis_tvalid);
    end
    n_checks++;
    if (m_axis_tdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_m_tdata: got %0d expected 0", m_axis_tdata);
    end
`ifdef AXIS_GATE_CNT_SAT_EN
    n_checks++;
    if (m_axis_tuser !== 1'b0) begin
      n_fail++; $display("FAIL reset_m_tuser: got %b expected 0", m_axis_tuser);
    end
`endif
    aresetn = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL release_s_tready: got %b expected 0", s_axis_tready);
    end
    step();
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL first_clk_s_tready: got %b expected 1", s_axis_tready);
    end
  endtask

  task automatic test_gate_basic();
    int acc;
    sig_period = 10;
    repeat (5) step();
    start_gate(100, acc);
    wait_valid(200);
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL basic_tvalid: got %b expected 1", m_axis_tvalid);
    end
    n_checks++;
    if (cyc - acc !== 100) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 100", cyc - acc);
    end
    n_checks++;
    if (m_axis_tdata !== 32'd10) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 10", m_axis_tdata);
    end
`ifdef AXIS_GATE_CNT_SAT_EN
    n_checks++;
    if (m_axis_tuser !== 1'b0) begin
      n_fail++; $display("FAIL basic_tuser: got %b expected 0", m_axis_tuser);
    end
`endif
    step();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL basic_return_idle: got tvalid=%b tready=%b expected 0/1",
                         m_axis_tvalid, s_axis_tready);
    end
  endtask

  task automatic test_zero_gate();
    int acc;
    sig_period = 0;
    sig_in = 1'b0;
    repeat (5) step();
    sig_in = 1'b1;
    step();
    s_axis_tdata  = 32'd0;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    step();
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin
      n_fail++; $display("FAIL zero_gate_edge: got tvalid=%b count=%0d expected 1/1",
                         m_axis_tvalid, m_axis_tdata);
    end
    step();
    start_gate(0, acc);
    wait_valid(10);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0 || cyc - acc !== 1) begin
      n_fail++; $display("FAIL zero_gate_no_edge: got tvalid=%b count=%0d lat=%0d expected 1/0/1",
                         m_axis_tvalid, m_axis_tdata, cyc - acc);
    end
    step();
  endtask

  task automatic test_hold_stall();
    int   acc;
    logic stable = 1'b1;
    m_axis_tready = 1'b0;
    sig_period = 4;
    repeat (5) step();
    start_gate(20, acc);
    wait_valid(50);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd5) begin
      n_fail++; $display("FAIL stall_result: got tvalid=%b count=%0d expected 1/5",
                         m_axis_tvalid, m_axis_tdata);
    end
    s_axis_tdata  = 32'd7;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd5 || s_axis_tready !== 1'b0) stable = 0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL stall_stable: got %b expected 1", stable);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    step();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got tvalid=%b tready=%b expected 0/1",
                         m_axis_tvalid, s_axis_tready);
    end
  endtask

  task automatic test_overflow();
    int acc;
    sig_period = 2;
    repeat (4) step();
    start_gate(40, acc);
    wait_valid(60);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd20) begin
      n_fail++; $display("FAIL ovf_wide_count: got tvalid=%b count=%0d expected 1/20",
                         m_axis_tvalid, m_axis_tdata);
    end
`ifdef AXIS_GATE_CNT_SAT_EN
    n_checks++;
    if (m4_tdata !== 4'd15) begin
      n_fail++; $display("FAIL ovf_narrow_sat: got %0d expected 15", m4_tdata);
    end
    n_checks++;
    if (m4_tuser !== 1'b1) begin
      n_fail++; $display("FAIL ovf_narrow_tuser: got %b expected 1", m4_tuser);
    end
`else
    n_checks++;
    if (m4_tdata !== 4'd4) begin
      n_fail++; $display("FAIL ovf_narrow_wrap: got %0d expected 4", m4_tdata);
    end
`endif
    step();
  endtask

  task automatic test_async_reset();
    int   acc;
    logic spurious = 1'b0;
    sig_period = 5;
    start_gate(30, acc);
    repeat (10) step();
    #2 aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL arst_outputs: got tvalid=%b tdata=%0d tready=%b expected 0/0/0",
                         m_axis_tvalid, m_axis_tdata, s_axis_tready);
    end
    repeat (2) step();
    aresetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_axis_tvalid !== 1'b0) spurious = 1'b1;
    end
    n_checks++;
    if (spurious !== 1'b0) begin
      n_fail++; $display("FAIL arst_spurious: got %b expected 0", spurious);
    end
    start_gate(30, acc);
    wait_valid(60);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd6) begin
      n_fail++; $display("FAIL arst_remeasure: got tvalid=%b count=%0d expected 1/6",
                         m_axis_tvalid, m_axis_tdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int a0;
    int exp_cnt;
    int guard = 0;
    sig_period = 7;
    m_axis_tready = 1'b1;
    repeat (10) step();
    while (!s_axis_tready && guard < 100) begin
      step();
      guard++;
    end
    s_axis_tdata  = 32'd8;
    s_axis_tvalid = 1'b1;
    step();
    a0 = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_valid(30);
      exp_cnt = pulses(a0 + 10 * k + 1, a0 + 10 * k + 8);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || cyc !== a0 + 10 * k + 8) begin
        n_fail++; $display("FAIL b2b_timing[%0d]: got tvalid=%b at %0d expected 1 at %0d",
                           k, m_axis_tvalid, cyc, a0 + 10 * k + 8);
      end
      n_checks++;
      if (m_axis_tdata !== 32'(exp_cnt)) begin
        n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, m_axis_tdata, exp_cnt);
      end
    end
    s_axis_tvalid = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    aresetn       = 1'b0;
    sig_in        = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4096; i++) sv[i] = 1'b0;
    test_reset();
    test_gate_basic();
    test_zero_gate();
    test_hold_stall();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
